mem_line_responder: RTL and testbench
=====================================

Name: mem_line_responder

Overview:
- Main-memory responder for the cache's line-granular memory interface (mem_r / mem_w / mem_addr / 128-bit data / mem_ready).
- Holds a synchronous array of 128-bit lines and services one request at a time with programmable latency.
- Acts as the backing store behind the set-associative caches in simulation and on FPGA.
- Filters transient requests: a request that drops or changes before completion is abandoned and never committed.

Parameters:
- ADDR_WIDTH, 8, line-index bits; depth = 2^ADDR_WIDTH lines.
- LINE_WIDTH, 128, line width in bits; fixed at 128 by the interface.
- LATENCY, 4, cycles from request acceptance to mem_ready; legal range 1..255.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_r  in  1  line read request, level, held by initiator until mem_ready.
- mem_w  in  1  line write request, level, held until mem_ready.
- mem_addr  in  32  byte address; line index = mem_addr[ADDR_WIDTH+3:4]; bits [3:0] and upper bits ignored.
- mem_w_data  in  128  write line data.
- mem_r_data  out  128  read line data, registered, valid only while mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE, mem_ready=0, mem_r_data=0, counter=0, latched request cleared. Array contents are not reset.
- State IDLE:
  - Sample mem_w|mem_r each cycle.
  - On a request, latch op (write if mem_w=1; mem_w wins if both are high), line index and mem_w_data.
  - Load counter with LATENCY-1. Go to BUSY, or to RESP when LATENCY=1.
- State BUSY, checked every cycle:
  - Abort to IDLE, no array write, no mem_ready, if mem_r=mem_w=0, or the latched op differs from the current request op, or the current line index differs from the latched index.
  - For writes, mem_w_data is re-latched every BUSY cycle; the last value wins.
  - Otherwise decrement the counter; when it reaches 0, go to RESP.
- State RESP (one cycle):
  - mem_ready=1.
  - Read: mem_r_data = array[index], registered on entry to RESP.
  - Write: array[index] <= latched data at the end of this cycle; mem_r_data = latched write data.
  - Next state is IDLE.
- Latency: request first high in cycle T → mem_ready high in cycle T+LATENCY, exactly one cycle.
- Handshake:
  - The initiator drops or replaces its request in the cycle after mem_ready.
  - A new request present in the first IDLE cycle after RESP is accepted with no gap. This covers a write-back followed immediately by a refill read.
- Read-after-write to the same line on the next transaction returns the new data.
- Outside RESP, mem_ready=0 and mem_r_data=0.
- Reset asserted mid-BUSY or mid-RESP:
  - Immediate return to IDLE; mem_ready drops asynchronously.
  - A pending write is discarded.
  - A write whose RESP edge coincides with reset assertion is not committed.
- Index wrap: addresses differing only above bit ADDR_WIDTH+3 alias to the same line.

Optional Feature:
- MEM_STATS_EN defined: adds three outputs rd_cnt[31:0], wr_cnt[31:0], abort_cnt[31:0].
  - Reset to 0.
  - rd_cnt / wr_cnt increment on each completed read / write (RESP cycle).
  - abort_cnt increments on each BUSY→IDLE abort.
  - All three saturate at 0xFFFFFFFF.
- MEM_STATS_EN undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Write then read back, LATENCY=4: mem_w=1, addr 0x0000_0040, data 0x0123…CDEF held from cycle 0 → mem_ready only in cycle 4. Then mem_r addr 0x0000_0040 from cycle 5 → mem_ready in cycle 9 with mem_r_data=0x0123…CDEF.
- Transient abort: mem_w=1 at addr 0x0 for one cycle, then mem_r at addr 0x80 held → no write to line 0 (line 0 reads back its prior value). mem_ready arrives 4 cycles after mem_r first high, returning line 8.
- Aliasing, ADDR_WIDTH=8: write 0xAAAA…AAAA to 0x0000_1010, then read 0x0000_0010 → 0xAAAA…AAAA (both index 0x01). Read of 0x0000_001C also returns it (offset bits ignored).
- Back-to-back write-back then refill: mem_w at 0x100 completes in cycle 4; mem_r at 0x200 starts in cycle 5 → accepted in cycle 5, mem_ready in cycle 9, mem_w_data committed to line 0x10.
- Reset mid-BUSY: write to 0x300 starts in cycle 0, rst pulsed in cycle 2 → mem_ready never asserted, line 0x30 unchanged. A subsequent read after rst release completes normally after 4 cycles.
- MEM_STATS_EN: 2 reads, 1 write, 1 abort → rd_cnt=2, wr_cnt=1, abort_cnt=1; rst clears all three to 0.

Source files
------------

// File: rtl/mem_line_responder.sv
// mem_line_responder: line-granular backing-store memory with programmable latency.
//
// Services one mem_r / mem_w request at a time. A request first high in cycle T
// sees a one-cycle mem_ready pulse in cycle T+LATENCY. A request that drops,
// changes op, or changes line index before completion is abandoned and never
// committed. If a different request replaces it, that request is accepted in the
// same cycle as the abandonment, so it still completes LATENCY cycles after it
// first appeared.
//
// Parameters:
//   ADDR_WIDTH  line-index bits; depth = 2^ADDR_WIDTH lines
//   LINE_WIDTH  line width in bits; fixed at 128 by the interface
//   LATENCY     cycles from request to mem_ready, 1..255
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   mem_r        line read request, level
//   mem_w        line write request, level; wins over mem_r
//   mem_addr     byte address; line index = mem_addr[ADDR_WIDTH+3:4]
//   mem_w_data   write line data
//   mem_r_data   registered response data; zero unless mem_ready
//   mem_ready    one-cycle completion pulse
//
// Optional feature, macro MEM_STATS_EN:
//   rd_cnt, wr_cnt, abort_cnt  saturating 32-bit counters of completed reads,
//                              completed writes and abandoned requests.
module mem_line_responder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_r,
  input  logic                  mem_w,
  input  logic [31:0]           mem_addr,
  input  logic [LINE_WIDTH-1:0] mem_w_data,
`ifdef MEM_STATS_EN
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt,
  output logic [31:0]           abort_cnt,
`endif
  output logic [LINE_WIDTH-1:0] mem_r_data,
  output logic                  mem_ready
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam logic [7:0] LatM1  = 8'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                  state_q;
  logic                    op_w_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [LINE_WIDTH-1:0]   wdata_q;
  logic [7:0]              cnt_q;
  logic                    ready_q;
  logic [LINE_WIDTH-1:0]   rdata_q;
  logic [LINE_WIDTH-1:0]   mem_q [Depth];

  logic                    req;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    busy_abort;
  logic                    unused_addr;

  assign req         = mem_r | mem_w;
  assign idx         = mem_addr[ADDR_WIDTH+3:4];
  assign unused_addr = ^{mem_addr[31:ADDR_WIDTH+4], mem_addr[3:0]};

  // The current request no longer matches the one being serviced.
  assign busy_abort = (state_q == StBusy) &&
                      (!req || (mem_w != op_w_q) || (idx != idx_q));

  assign mem_ready  = ready_q;
  assign mem_r_data = rdata_q;

  // The array write sits in the reset block so a write whose RESP edge coincides
  // with reset assertion is dropped. Array contents themselves are never reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_w_q  <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      unique case (state_q)
        StIdle, StBusy: begin
          if (state_q == StIdle || busy_abort) begin
            if (req) begin
              op_w_q  <= mem_w;
              idx_q   <= idx;
              wdata_q <= mem_w_data;
              if (LATENCY == 1) begin
                state_q <= StResp;
                cnt_q   <= '0;
                ready_q <= 1'b1;
                rdata_q <= mem_w ? mem_w_data : mem_q[idx];
              end else begin
                state_q <= StBusy;
                cnt_q   <= LatM1;
              end
            end else begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end
          end else begin
            // Write data tracks the initiator; the final BUSY cycle's value is committed.
            if (op_w_q) begin
              wdata_q <= mem_w_data;
            end
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              state_q <= StResp;
              ready_q <= 1'b1;
              rdata_q <= op_w_q ? mem_w_data : mem_q[idx_q];
            end
          end
        end
        StResp: begin
          state_q <= StIdle;
          if (op_w_q) begin
            mem_q[idx_q] <= wdata_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MEM_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;
  logic [31:0] abort_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      abort_cnt_q <= '0;
    end else begin
      if (state_q == StResp && !op_w_q && rd_cnt_q != 32'hFFFF_FFFF) begin
        rd_cnt_q <= rd_cnt_q + 32'd1;
      end
      if (state_q == StResp && op_w_q && wr_cnt_q != 32'hFFFF_FFFF) begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end
      if (busy_abort && abort_cnt_q != 32'hFFFF_FFFF) begin
        abort_cnt_q <= abort_cnt_q + 32'd1;
      end
    end
  end

  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: stimulus tasks push expected
// responses (completion cycle + data) from a line-array model; a negedge
// monitor pops and compares whenever mem_ready is seen.
module tb_mem_line_responder;

  localparam int unsigned LAT = 4;

  logic         clk;
  logic         rst;
  logic         mem_r;
  logic         mem_w;
  logic [31:0]  mem_addr;
  logic [127:0] mem_w_data;
  logic [127:0] mem_r_data;
  logic         mem_ready;
`ifdef MEM_STATS_EN
  logic [31:0]  rd_cnt;
  logic [31:0]  wr_cnt;
  logic [31:0]  abort_cnt;
`endif

  mem_line_responder #(
    .ADDR_WIDTH(8),
    .LINE_WIDTH(128),
    .LATENCY   (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_r     (mem_r),
    .mem_w     (mem_w),
    .mem_addr  (mem_addr),
    .mem_w_data(mem_w_data),
`ifdef MEM_STATS_EN
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt),
    .abort_cnt (abort_cnt),
`endif
    .mem_r_data(mem_r_data),
    .mem_ready (mem_ready)
  );

  typedef struct {
    int           c;
    logic [127:0] d;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] model [256];
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  int           m_rd = 0;
  int           m_wr = 0;
  int           m_ab = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] line_of(input logic [31:0] a);
    return a[11:4];
  endfunction

  // Monitor: every cycle, either a scheduled response or quiet outputs.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].c < cyc) begin
      total++;
      bad++;
      $display("FAIL missed_ready: due cycle %0d, now %0d, no mem_ready seen", sb[0].c, cyc);
      void'(sb.pop_front());
    end
    total++;
    if (mem_ready) begin
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ready: cycle %0d data %h, nothing pending", cyc, mem_r_data);
      end else begin
        e = sb.pop_front();
        if (e.c != cyc || mem_r_data !== e.d) begin
          bad++;
          $display("FAIL resp: got cycle %0d data %h, want cycle %0d data %h",
                   cyc, mem_r_data, e.c, e.d);
        end
      end
    end else if (mem_r_data !== 128'd0) begin
      bad++;
      $display("FAIL idle_data: cycle %0d mem_r_data %h, want 0", cyc, mem_r_data);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    mem_r = 1'b0;
    mem_w = 1'b0;
    repeat (n) next_cycle();
  endtask

  // Full transaction. Returns at the start of the cycle after mem_ready with the
  // request still driven, so the caller may chain another one with no gap.
  task automatic txn(input bit w, input logic [31:0] a, input logic [127:0] d, input bit vary);
    logic [127:0] cur;
    logic [31:0]  r;
    int           t0;
    exp_t         e;
    cur        = d;
    t0         = cyc;
    mem_w      = w;
    mem_r      = w ? 1'($urandom % 2) : 1'b1;
    mem_addr   = a;
    mem_w_data = cur;
    if (!w) begin
      e.c = t0 + LAT;
      e.d = model[line_of(a)];
      sb.push_back(e);
      m_rd++;
    end
    for (int k = 1; k < LAT; k++) begin
      next_cycle();
      if (vary) begin
        r        = $urandom;
        mem_addr = {r[31:12], a[11:4], r[3:0]};
        if (w) begin
          cur        = rand128();
          mem_w_data = cur;
        end
      end
    end
    if (w) begin
      e.c = t0 + LAT;
      e.d = cur;
      sb.push_back(e);
      model[line_of(a)] = cur;
      m_wr++;
    end
    next_cycle();
    if (vary) mem_w_data = rand128();
    next_cycle();
  endtask

  // Holds a request for n cycles; the caller changes or drops it afterwards.
  task automatic abort_req(input bit w, input logic [31:0] a, input int n);
    mem_w      = w;
    mem_r      = w ? 1'($urandom % 2) : 1'b1;
    mem_addr   = a;
    mem_w_data = rand128();
    repeat (n) next_cycle();
    m_ab++;
  endtask

  // Request interrupted by a one-cycle reset pulse k cycles after it starts.
  task automatic txn_reset(input bit w, input logic [31:0] a, input int k);
    mem_w      = w;
    mem_r      = !w;
    mem_addr   = a;
    mem_w_data = rand128();
    repeat (k) next_cycle();
    rst   = 1'b1;
    mem_r = 1'b0;
    mem_w = 1'b0;
    m_rd  = 0;
    m_wr  = 0;
    m_ab  = 0;
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  initial begin
    logic [31:0]  a;
    logic [127:0] pat;
    bit           w;
    int           kind;
    int           sel;

    rst        = 1'b1;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    mem_addr   = '0;
    mem_w_data = '0;
    @(negedge clk);
    total++;
    if (mem_ready !== 1'b0 || mem_r_data !== 128'd0) begin
      bad++;
      $display("FAIL reset_state: ready %b data %h, want 0 and 0", mem_ready, mem_r_data);
    end
    next_cycle();
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Give every line a known value.
    for (int i = 0; i < 256; i++) txn(1'b1, 32'(i) << 4, rand128(), 1'b0);
    idle(1);

    // Write then read back.
    pat = 128'h0123456789ABCDEF0123456789ABCDEF;
    txn(1'b1, 32'h0000_0040, pat, 1'b0);
    txn(1'b0, 32'h0000_0040, '0, 1'b0);
    idle(2);

    // Transient write to line 0 replaced by a read of line 8.
    abort_req(1'b1, 32'h0000_0000, 1);
    txn(1'b0, 32'h0000_0080, '0, 1'b0);
    txn(1'b0, 32'h0000_0000, '0, 1'b0);
    idle(1);

    // Aliasing above the index and inside the line offset.
    txn(1'b1, 32'h0000_1010, {4{32'hAAAA_AAAA}}, 1'b0);
    txn(1'b0, 32'h0000_0010, '0, 1'b0);
    txn(1'b0, 32'h0000_001C, '0, 1'b0);
    idle(1);

    // Write-back immediately followed by refill, then verify the write-back.
    txn(1'b1, 32'h0000_0100, rand128(), 1'b0);
    txn(1'b0, 32'h0000_0200, '0, 1'b0);
    txn(1'b0, 32'h0000_0100, '0, 1'b0);
    idle(1);

    // Reset mid-BUSY and mid-RESP: neither write may land.
    txn_reset(1'b1, 32'h0000_0300, 2);
    txn(1'b0, 32'h0000_0300, '0, 1'b0);
    idle(1);
    txn_reset(1'b1, 32'h0000_0300, LAT);
    txn(1'b0, 32'h0000_0300, '0, 1'b0);
    idle(1);

    // Random traffic mixing complete transactions and abandoned ones.
    for (int i = 0; i < 250; i++) begin
      kind = int'($urandom % 10);
      w    = 1'($urandom % 2);
      a    = $urandom;
      if (kind < 3) begin
        abort_req(w, a, 1 + int'($urandom % (LAT - 1)));
        sel = int'($urandom % 3);
        if (sel == 0) idle(1 + int'($urandom % 2));
        else if (sel == 1) txn(!w, a, rand128(), 1'b1);
        else txn(w, a + 32'h10, rand128(), 1'b1);
      end else begin
        txn(w, a, rand128(), 1'b1);
      end
      if ($urandom % 2 == 1) idle(int'($urandom % 3));
    end
    idle(LAT + 3);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d responses outstanding, want 0", sb.size());
    end

`ifdef MEM_STATS_EN
    total++;
    if (rd_cnt != 32'(m_rd) || wr_cnt != 32'(m_wr) || abort_cnt != 32'(m_ab)) begin
      bad++;
      $display("FAIL stats: rd %0d wr %0d ab %0d, want %0d %0d %0d",
               rd_cnt, wr_cnt, abort_cnt, m_rd, m_wr, m_ab);
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    total++;
    if (rd_cnt != 32'd0 || wr_cnt != 32'd0 || abort_cnt != 32'd0) begin
      bad++;
      $display("FAIL stats_reset: rd %0d wr %0d ab %0d, want 0 0 0", rd_cnt, wr_cnt, abort_cnt);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
